// File: rtl/adc_sampler.sv
// adc_sampler: periodically triggers a 16-clock SPI read of a 12-bit ADC
// (4 leading zeros, then D11..D0, MSB first) and averages 2^AVG_LOG2
// conversions into each data1 word. new_Data strobes for one cycle per word.
module adc_sampler #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        adc_miso,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic [11:0] data1,
    output logic        new_Data,
    output logic        busy,
    output logic        sample_missed,
    output logic        frame_err
);

    localparam int unsigned PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned AW = 12 + AVG_LOG2;
    localparam int unsigned CW = AVG_LOG2 + 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CS_SETUP = 3'd1;
    localparam logic [2:0] SHIFT    = 3'd2;
    localparam logic [2:0] CS_HOLD  = 3'd3;
    localparam logic [2:0] ACCUM    = 3'd4;

    localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(2 ** AVG_LOG2);

    logic [2:0]    state;
    logic [PW-1:0] per_cnt;
    logic [DW-1:0] div_cnt;
    logic [4:0]    half_cnt;
    logic [15:0]   shreg;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    logic          trigger;
    logic          div_done;
    logic [AW-1:0] sum;
    logic [AW-1:0] avg;
    logic [CW-1:0] cnt_inc;

    assign trigger  = enable && (per_cnt == PER_LAST);
    assign div_done = (div_cnt == DIV_LAST);
    assign sum      = acc + AW'(shreg[11:0]);
    assign avg      = sum >> AVG_LOG2;
    assign cnt_inc  = cnt + 1'b1;

    // Pin and status decode straight from state so reset acts in the same cycle
    always_comb begin
        busy     = (state != IDLE);
        adc_cs_n = !((state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD));
        adc_sclk = (state == SHIFT) ? half_cnt[0] : 1'b1;
    end

    // Free-running period counter; held at zero while sampling is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (!enable || trigger) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // Frame sequencer: CS setup, 32 SCLK half-periods, CS hold, one accumulate cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt  <= '0;
                    half_cnt <= '0;
                    if (trigger) state <= CS_SETUP;
                end
                CS_SETUP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // Odd half-periods are SCLK high; capture in their first cycle
                    if (half_cnt[0] && (div_cnt == '0)) shreg <= {shreg[14:0], adc_miso};
                    if (div_done) begin
                        div_cnt <= '0;
                        if (half_cnt == 5'd31) begin
                            half_cnt <= '0;
                            state    <= CS_HOLD;
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= ACCUM;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ACCUM:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Averaging, output word, strobe and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc           <= '0;
            cnt           <= '0;
            data1         <= '0;
            new_Data      <= 1'b0;
            sample_missed <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            new_Data <= 1'b0;
            if (trigger && (state != IDLE)) sample_missed <= 1'b1;
            if (state == ACCUM) begin
                if (shreg[15:12] != 4'd0) frame_err <= 1'b1;
                if (cnt_inc == CNT_FULL) begin
                    data1    <= avg[11:0];
                    new_Data <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt_inc;
                end
            end else if ((state == IDLE) && !enable) begin
                // Disabled: drop any partial average
                acc <= '0;
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: directed bench with behavioural ADC models and a scoreboard
// of expected data1 words. dut_a: no averaging, period 200. dut_b: 4-way
// averaging, period 100 (shorter than a frame, so triggers get missed).
module tb_adc_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, en_a = 1'b0, miso_a, sclk_a, cs_n_a, new_a, busy_a, missed_a, ferr_a;
    logic        rst_b = 1'b1, en_b = 1'b0, miso_b, sclk_b, cs_n_b, new_b, busy_b, missed_b, ferr_b;
    logic [11:0] data_a, data_b;

    adc_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .AVG_LOG2(0)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .adc_miso(miso_a), .adc_sclk(sclk_a),
        .adc_cs_n(cs_n_a), .data1(data_a), .new_Data(new_a), .busy(busy_a),
        .sample_missed(missed_a), .frame_err(ferr_a)
    );

    adc_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(100), .AVG_LOG2(2)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .adc_miso(miso_b), .adc_sclk(sclk_b),
        .adc_cs_n(cs_n_b), .data1(data_b), .new_Data(new_b), .busy(busy_b),
        .sample_missed(missed_b), .frame_err(ferr_b)
    );

    // ADC models: word preloaded while CS is high, advanced on each SCLK fall
    // that follows a rise, so bit 15 is presented for the first rising edge.
    logic [15:0] word_a = 16'h0, sh_a = 16'h0, word_b = 16'h0, sh_b = 16'h0;
    logic        prev_a = 1'b1, rs_a = 1'b0, prev_b = 1'b1, rs_b = 1'b0;
    int          rises_a = 0, strobes_a = 0, strobes_b = 0;

    assign miso_a = sh_a[15];
    assign miso_b = sh_b[15];

    always @(negedge clk) begin
        if (new_a) strobes_a <= strobes_a + 1;
        if (cs_n_a) begin
            sh_a <= word_a;
            rs_a <= 1'b0;
        end else if (!prev_a && sclk_a) begin
            rs_a    <= 1'b1;
            rises_a <= rises_a + 1;
        end else if (prev_a && !sclk_a && rs_a) begin
            sh_a <= {sh_a[14:0], 1'b0};
        end
        prev_a <= sclk_a;
    end

    always @(negedge clk) begin
        if (new_b) strobes_b <= strobes_b + 1;
        if (cs_n_b) begin
            sh_b <= word_b;
            rs_b <= 1'b0;
        end else if (!prev_b && sclk_b) begin
            rs_b <= 1'b1;
        end else if (prev_b && !sclk_b && rs_b) begin
            sh_b <= {sh_b[14:0], 1'b0};
        end
        prev_b <= sclk_b;
    end

    int          total = 0;
    int          bad = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cs_of(input bit b);
        return b ? cs_n_b : cs_n_a;
    endfunction

    function automatic logic new_of(input bit b);
        return b ? new_b : new_a;
    endfunction

    task automatic wait_cs(input bit b, input logic lvl, input int budget, output int n);
        n = 0;
        while (cs_of(b) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("cs_wait", cs_of(b), lvl);
    endtask

    task automatic wait_strobe(input bit b, input int budget, output int n);
        n = 0;
        while (new_of(b) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("strobe_wait", new_of(b), 1'b1);
    endtask

    task automatic pop_check(input bit b);
        logic [11:0] e;
        check("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("data1", b ? data_b : data_a, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, m, low, r0, s0;
        logic [15:0] w1[4];
        logic [15:0] w2[4];
        w1 = '{16'd100, 16'd101, 16'd102, 16'd104};
        w2 = '{16'd1000, 16'd1001, 16'd1003, 16'd1010};

        // Reset state
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("rst_cs_n", cs_n_a, 1'b1);
        check("rst_sclk", sclk_a, 1'b1);
        check("rst_data1", data_a, 12'h0);
        check("rst_new", new_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_missed", missed_a, 1'b0);
        check("rst_ferr", ferr_a, 1'b0);
        check("rst_b_cs_n", cs_n_b, 1'b1);

        // Single conversion, no averaging: latency, CS width, SCLK edge count
        word_a = 16'h0ABC;
        exp_q.push_back(12'hABC);
        en_a = 1'b1;
        wait_cs(0, 1'b0, 400, n);
        check("trig_latency", n, 200);
        r0  = rises_a;
        low = 1;
        m   = 0;
        while (new_a !== 1'b1 && m < 300) begin
            @(negedge clk);
            m++;
            if (cs_n_a === 1'b0) low++;
        end
        check("strobe_latency", m, 137);
        check("cs_low_cycles", low, 136);
        check("sclk_rises", rises_a - r0, 16);
        pop_check(0);
        check("ferr_clean", ferr_a, 1'b0);
        @(negedge clk);
        check("strobe_one_cycle", new_a, 1'b0);
        check("data_hold", data_a, 12'hABC);

        // Nonzero leading nibble: flagged, low 12 bits still used
        word_a = 16'h8FFF;
        exp_q.push_back(12'hFFF);
        wait_strobe(0, 400, m);
        pop_check(0);
        check("ferr_set", ferr_a, 1'b1);
        check("no_missed_a", missed_a, 1'b0);

        // Reset in SHIFT half-period 10, then a clean frame
        word_a = 16'h0123;
        wait_cs(0, 1'b0, 400, n);
        repeat (44) @(negedge clk);
        check("sclk_hp10_low", sclk_a, 1'b0);
        s0    = strobes_a;
        rst_a = 1'b1;
        #1;
        check("midrst_cs_n", cs_n_a, 1'b1);
        check("midrst_sclk", sclk_a, 1'b1);
        check("midrst_busy", busy_a, 1'b0);
        check("midrst_data1", data_a, 12'h0);
        check("midrst_ferr", ferr_a, 1'b0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        exp_q.push_back(12'h123);
        wait_cs(0, 1'b0, 400, n);
        check("trig_after_rst", n, 200);
        wait_strobe(0, 300, m);
        pop_check(0);
        check("ferr_after_rst", ferr_a, 1'b0);
        @(negedge clk);
        check("strobes_after_rst", strobes_a - s0, 1);
        en_a = 1'b0;

        // Four-way average with an undersized period: every other trigger missed
        s0     = strobes_b;
        word_b = w1[0];
        exp_q.push_back(12'd101);
        en_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            word_b = w1[i];
            wait_cs(1, 1'b0, 300, n);
            wait_cs(1, 1'b1, 300, n);
            if (i == 2) check("no_early_strobe", strobes_b - s0, 0);
        end
        wait_strobe(1, 10, m);
        pop_check(1);
        @(negedge clk);
        check("b_strobe_one_cycle", new_b, 1'b0);
        check("b_strobe_count", strobes_b - s0, 1);
        check("missed_set", missed_b, 1'b1);
        check("b_ferr_clean", ferr_b, 1'b0);

        // Disable after two frames: partial average must be discarded
        s0     = strobes_b;
        word_b = 16'd500;
        for (int i = 0; i < 2; i++) begin
            wait_cs(1, 1'b0, 300, n);
            wait_cs(1, 1'b1, 300, n);
        end
        en_b = 1'b0;
        repeat (20) @(negedge clk);
        check("no_strobe_partial", strobes_b - s0, 0);
        check("idle_when_off", busy_b, 1'b0);
        exp_q.push_back(12'd1003);
        word_b = w2[0];
        en_b   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            word_b = w2[i];
            wait_cs(1, 1'b0, 300, n);
            wait_cs(1, 1'b1, 300, n);
        end
        wait_strobe(1, 10, m);
        pop_check(1);
        @(negedge clk);
        check("reenable_strobes", strobes_b - s0, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
